dma_axi_mem_slave: RTL and testbench
====================================

Name: dma_axi_mem_slave

Overview:
- AXI4 slave (responder) backed by a byte-enabled on-chip memory.
- Serves as the far end of the DMA master interface: the DMA's memory-to-memory target in SoC integration and the reference responder in block-level DMA testbenches.
- Independent read and write channels; one outstanding transaction per channel; INCR bursts at one beat per cycle; back-pressure honoured on R and B.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of memory word 0
- MEM_DEPTH, 1024, number of bus-width words
- DATA_WIDTH, 512, bus data width in bits (BYTES = DATA_WIDTH/8)
- ADDR_WIDTH, 32, AXI address width

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- axi_req_i  input  axi_req_t  AW/W/AR channels plus bready/rready from the master
- axi_resp_o  output  axi_resp_t  awready/wready/arready plus B/R channels to the master
- err_cnt_o  output  16  saturating count of SLVERR responses issued (B responses + R beats)

Behaviour:
- Reset (asynchronous, rstn low): all outputs 0 except awready=1 and arready=1; both FSMs go to IDLE; err_cnt_o=0. Memory contents are not reset.
- Index: idx = (addr - BASE_ADDR) >> log2(BYTES); the low address bits are ignored.
- Range check: a beat is in range iff BASE_ADDR <= addr < BASE_ADDR + MEM_DEPTH*BYTES. The check is done per beat, so a burst that runs off the end errors only on its out-of-range beats.
- AxSIZE is ignored: every beat is full width, and write strobes select bytes.
- Burst type: FIXED keeps the address constant, INCR adds BYTES per beat, WRAP returns SLVERR on all beats.
- Read FSM RD_IDLE -> RD_DATA:
  - In RD_IDLE, arready=1. On the AR handshake in cycle N: latch id/addr/len, load rdata <= mem[idx] (0 if the beat errors), and set rvalid=1 in cycle N+1.
  - In RD_DATA: rid = latched id, rresp = OKAY or SLVERR per beat, rlast = (beat == len).
  - rdata/rresp/rlast stay stable while rvalid && !rready.
  - On rvalid && rready: if not last, advance the address and load the next beat in the same edge (no bubble). If last, drop rvalid and return to RD_IDLE with arready=1 in the next cycle.
- Write FSM WR_IDLE -> WR_DATA -> WR_RESP:
  - In WR_IDLE, awready=1. The AW handshake latches id/addr/len/burst and moves to WR_DATA with wready=1.
  - Each wvalid && wready beat writes mem[idx] bytes where wstrb=1, unless the beat errors; erroring beats are discarded.
  - The beat counter is authoritative. The last beat is counted beat == len; wlast not asserted on it, or asserted earlier, sets a sticky SLVERR for the burst.
  - After the last beat: move to WR_RESP with bvalid=1, bid = latched id, bresp = OKAY unless any beat errored (then SLVERR).
  - Hold the response until bready, then return to WR_IDLE.
  - W beats arriving before the AW handshake are not accepted (wready=0 in WR_IDLE).
- Simultaneous read and write to the same word in the same cycle: the read captures the old data and the write takes effect at that edge.
- Back-to-back: a new AR is accepted at the earliest in the cycle after the last R handshake (same for AW after B).
- err_cnt_o increments by 1 per SLVERR R beat handshake and per SLVERR B handshake, by 2 when both occur in the same cycle, and saturates at 16'hFFFF.
- Reset asserted mid-burst aborts both channels immediately. No further response is issued, and writes already performed persist.

Decomposition:
- dma_pkg additions:
  - AXI_RESP_OKAY = 2'b00 and AXI_RESP_SLVERR = 2'b10
  - AXI_BURST_FIXED/INCR/WRAP
  - enum e_slv_rd_st_t {RD_IDLE, RD_DATA}
  - enum e_slv_wr_st_t {WR_IDLE, WR_DATA, WR_RESP}
- Sub-module dma_mem_bank: a MEM_DEPTH x DATA_WIDTH array with one byte-enabled write port and one synchronous-capture read port. It isolates the memory so it can be swapped for an SRAM macro later.

Test Plan:
- Write then read:
  - Stimulus: AW addr=BASE_ADDR, len=3, INCR, wstrb all-ones, data 0..3, then AR to the same address with len=3.
  - Required response: bresp=OKAY, then 4 R beats data 0..3 with rlast only on beat 3, and the first rvalid exactly 1 cycle after the AR handshake.
- Partial strobe:
  - Stimulus: fill word 5 with all-FF, then write word 5 with data 0 and wstrb=64'h0000_0000_0000_000F.
  - Required response: a read of word 5 returns 0 in bytes 0-3 and FF in all other bytes.
- Back-pressure:
  - Stimulus: 8-beat read with rready toggling 1/0 every cycle.
  - Required response: rdata is held while stalled, all 8 beats arrive in order, and arready returns to 1 the cycle after the last handshake.
- Range and burst errors:
  - Stimulus: a 4-beat read starting at the last valid word, then a WRAP write.
  - Required response for the read: beat 0 OKAY with correct data; beats 1-3 SLVERR with data 0.
  - Required response for the WRAP write: bresp=SLVERR and memory unchanged.
  - err_cnt_o ends at 4.
- Concurrency and protocol:
  - Stimulus: an 8-beat write and an 8-beat read to disjoint regions issued in the same cycle with distinct IDs; then a 4-beat write with wlast early on beat 2.
  - Required response: both concurrent bursts complete in 8 beats with echoed bid/rid; the early-wlast write returns bresp=SLVERR.
- Reset mid-burst:
  - Stimulus: assert rstn=0 during beat 2 of a 4-beat read.
  - Required response: rvalid drops immediately; after release, arready=1 and awready=1, and a fresh read succeeds.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared AXI4 types and constants for the DMA memory-slave slice.
package dma_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 512;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;
  localparam int AXI_ID_W   = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } e_slv_rd_st_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } e_slv_wr_st_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   awid;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  bready;
    logic [AXI_ID_W-1:0]   arid;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  rready;
  } axi_req_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
  } axi_resp_t;

  // Only FIXED and INCR are served; WRAP and the reserved encoding error.
  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == AXI_BURST_FIXED) || (burst == AXI_BURST_INCR);
  endfunction

endpackage

// File: rtl/dma_mem_bank.sv
// Word-wide memory with one byte-enabled write port and one registered read port.
// Kept separate so it can be replaced by an SRAM macro.
module dma_mem_bank #(
  parameter  int DEPTH      = 1024,
  parameter  int DATA_WIDTH = 512,
  localparam int IDX_W      = $clog2(DEPTH),
  localparam int STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      widx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_W-1:0]     wstrb_i,
  input  logic                  re_i,
  input  logic [IDX_W-1:0]      ridx_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) begin
          mem_q[widx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Capture uses the pre-edge array, so a same-cycle write is not seen.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[ridx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dma_axi_mem_slave.sv
// AXI4 slave over on-chip memory: one outstanding burst per channel,
// per-beat range checking, SLVERR counter.
module dma_axi_mem_slave
  import dma_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    MEM_DEPTH  = 1024,
  parameter int                    DATA_WIDTH = 512
) (
  input  logic        clk,
  input  logic        rstn,
  input  axi_req_t    axi_req_i,
  output axi_resp_t   axi_resp_o,
  output logic [15:0] err_cnt_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] lo;
    logic [ADDR_WIDTH:0] ax;
    lo = {1'b0, BASE_ADDR};
    ax = {1'b0, a};
    return (ax >= lo) && (ax < lo + MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] addr2idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> OFF_W);
  endfunction

  function automatic logic beat_ok(input logic [1:0] burst, input logic [ADDR_WIDTH-1:0] a);
    return burst_ok(burst) && in_range(a);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [1:0] burst,
                                                      input logic [ADDR_WIDTH-1:0] a);
    return (burst == AXI_BURST_INCR) ? a + ADDR_WIDTH'(BYTES) : a;
  endfunction

  e_slv_rd_st_t          rd_st_q, rd_st_d;
  logic [AXI_ID_W-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]            rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [1:0]            rburst_q, rburst_d, rresp_q, rresp_d;
  logic                  rvalid_q, rvalid_d, rlast_q, rlast_d, arready_q, arready_d;

  e_slv_wr_st_t          wr_st_q, wr_st_d;
  logic [AXI_ID_W-1:0]   wid_q, wid_d, bid_q, bid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [1:0]            wburst_q, wburst_d, bresp_q, bresp_d;
  logic                  werr_q, werr_d, awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;

  logic [15:0]           err_cnt_q, err_cnt_d;

  logic                  ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;
  logic                  mem_re_s, mem_we_s;
  logic [IDX_W-1:0]      mem_ridx_s, mem_widx_s;
  logic [DATA_WIDTH-1:0] mem_rdata_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s;
  logic                  w_beat_ok_s, w_is_last_s, w_err_s;
  logic [1:0]            err_inc_s;
  logic [16:0]           err_sum_s;
  logic                  unused_size_s;

  assign unused_size_s = ^{axi_req_i.awsize, axi_req_i.arsize};

  // Read channel next-state: the next beat is fetched on the same edge as the R handshake.
  always_comb begin
    rd_st_d    = rd_st_q;
    rid_d      = rid_q;
    raddr_d    = raddr_q;
    rlen_d     = rlen_q;
    rburst_d   = rburst_q;
    rbeat_d    = rbeat_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    rvalid_d   = rvalid_q;
    arready_d  = arready_q;
    mem_re_s   = 1'b0;
    rd_addr_s  = raddr_q;
    ar_hs_s    = axi_req_i.arvalid && arready_q;
    r_hs_s     = rvalid_q && axi_req_i.rready;
    case (rd_st_q)
      RD_IDLE: begin
        if (ar_hs_s) begin
          rd_addr_s = axi_req_i.araddr;
          mem_re_s  = 1'b1;
          rid_d     = axi_req_i.arid;
          raddr_d   = axi_req_i.araddr;
          rlen_d    = axi_req_i.arlen;
          rburst_d  = axi_req_i.arburst;
          rbeat_d   = 8'd0;
          rresp_d   = beat_ok(axi_req_i.arburst, axi_req_i.araddr) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          rlast_d   = (axi_req_i.arlen == 8'd0);
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          rd_st_d   = RD_DATA;
        end else begin
          arready_d = 1'b1;
        end
      end
      RD_DATA: begin
        if (r_hs_s && rlast_q) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          rresp_d   = AXI_RESP_OKAY;
          arready_d = 1'b1;
          rd_st_d   = RD_IDLE;
        end else if (r_hs_s) begin
          rd_addr_s = next_addr(rburst_q, raddr_q);
          mem_re_s  = 1'b1;
          raddr_d   = rd_addr_s;
          rbeat_d   = rbeat_q + 8'd1;
          rresp_d   = beat_ok(rburst_q, rd_addr_s) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          rlast_d   = ((rbeat_q + 8'd1) == rlen_q);
        end else begin
          rvalid_d = 1'b1;
        end
      end
      default: begin
        rvalid_d  = 1'b0;
        arready_d = 1'b1;
        rd_st_d   = RD_IDLE;
      end
    endcase
    mem_ridx_s = addr2idx(rd_addr_s);
  end

  // Write channel next-state: the beat counter, not wlast, decides the end of the burst.
  always_comb begin
    wr_st_d     = wr_st_q;
    wid_d       = wid_q;
    waddr_d     = waddr_q;
    wlen_d      = wlen_q;
    wburst_d    = wburst_q;
    wbeat_d     = wbeat_q;
    werr_d      = werr_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    aw_hs_s     = axi_req_i.awvalid && awready_q;
    w_hs_s      = axi_req_i.wvalid && wready_q;
    b_hs_s      = bvalid_q && axi_req_i.bready;
    w_beat_ok_s = beat_ok(wburst_q, waddr_q);
    w_is_last_s = (wbeat_q == wlen_q);
    w_err_s     = werr_q || !w_beat_ok_s || (axi_req_i.wlast != w_is_last_s);
    mem_we_s    = w_hs_s && w_beat_ok_s;
    mem_widx_s  = addr2idx(waddr_q);
    case (wr_st_q)
      WR_IDLE: begin
        if (aw_hs_s) begin
          wid_d     = axi_req_i.awid;
          waddr_d   = axi_req_i.awaddr;
          wlen_d    = axi_req_i.awlen;
          wburst_d  = axi_req_i.awburst;
          wbeat_d   = 8'd0;
          werr_d    = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wr_st_d   = WR_DATA;
        end else begin
          awready_d = 1'b1;
        end
      end
      WR_DATA: begin
        if (w_hs_s && w_is_last_s) begin
          wready_d = 1'b0;
          bvalid_d = 1'b1;
          bid_d    = wid_q;
          bresp_d  = w_err_s ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          wr_st_d  = WR_RESP;
        end else if (w_hs_s) begin
          waddr_d = next_addr(wburst_q, waddr_q);
          wbeat_d = wbeat_q + 8'd1;
          werr_d  = w_err_s;
        end else begin
          wready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (b_hs_s) begin
          bvalid_d  = 1'b0;
          bresp_d   = AXI_RESP_OKAY;
          awready_d = 1'b1;
          wr_st_d   = WR_IDLE;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: begin
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        awready_d = 1'b1;
        wr_st_d   = WR_IDLE;
      end
    endcase
  end

  // One SLVERR per channel per cycle at most, so the increment is 0..2.
  always_comb begin
    err_inc_s = {1'b0, r_hs_s && (rresp_q == AXI_RESP_SLVERR)}
              + {1'b0, b_hs_s && (bresp_q == AXI_RESP_SLVERR)};
    err_sum_s = {1'b0, err_cnt_q} + {15'd0, err_inc_s};
    err_cnt_d = err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_st_q   <= RD_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= 8'd0;
      rburst_q  <= 2'd0;
      rbeat_q   <= 8'd0;
      rresp_q   <= AXI_RESP_OKAY;
      rlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
    end else begin
      rd_st_q   <= rd_st_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rburst_q  <= rburst_d;
      rbeat_q   <= rbeat_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rvalid_q  <= rvalid_d;
      arready_q <= arready_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_st_q   <= WR_IDLE;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= 8'd0;
      wburst_q  <= 2'd0;
      wbeat_q   <= 8'd0;
      werr_q    <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= AXI_RESP_OKAY;
      err_cnt_q <= 16'd0;
    end else begin
      wr_st_q   <= wr_st_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wburst_q  <= wburst_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  dma_mem_bank #(
    .DEPTH      (MEM_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank (
    .clk     (clk),
    .rstn    (rstn),
    .we_i    (mem_we_s),
    .widx_i  (mem_widx_s),
    .wdata_i (axi_req_i.wdata),
    .wstrb_i (axi_req_i.wstrb),
    .re_i    (mem_re_s),
    .ridx_i  (mem_ridx_s),
    .rdata_o (mem_rdata_s)
  );

  // Erroring beats present zero data; rdata is also zero whenever rvalid is low.
  always_comb begin
    axi_resp_o         = '0;
    axi_resp_o.awready = awready_q;
    axi_resp_o.wready  = wready_q;
    axi_resp_o.bid     = bid_q;
    axi_resp_o.bresp   = bresp_q;
    axi_resp_o.bvalid  = bvalid_q;
    axi_resp_o.arready = arready_q;
    axi_resp_o.rid     = rid_q;
    axi_resp_o.rdata   = (rvalid_q && (rresp_q == AXI_RESP_OKAY)) ? mem_rdata_s : '0;
    axi_resp_o.rresp   = rresp_q;
    axi_resp_o.rlast   = rlast_q;
    axi_resp_o.rvalid  = rvalid_q;
  end

  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_dma_axi_mem_slave.sv
// Scoreboard bench for dma_axi_mem_slave: drivers push expected B/R responses,
// a negedge monitor pops and compares them on each handshake.
module tb_dma_axi_mem_slave;
  import dma_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  axi_req_t req;
  axi_resp_t resp;
  logic [15:0] err_cnt;

  logic [3:0] awid = 4'd0, arid = 4'd0;
  logic [31:0] awaddr = 32'd0, araddr = 32'd0;
  logic [7:0] awlen = 8'd0, arlen = 8'd0;
  logic [1:0] awburst = 2'd0, arburst = 2'd0;
  logic awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic [511:0] wdata = '0;
  logic [63:0] wstrb = 64'd0;
  logic bready = 1'b1, rready = 1'b1;
  int rr_mode = 0;

  always_comb begin
    req = '0;
    req.awid = awid; req.awaddr = awaddr; req.awlen = awlen; req.awsize = 3'd6;
    req.awburst = awburst; req.awvalid = awvalid;
    req.wdata = wdata; req.wstrb = wstrb; req.wlast = wlast; req.wvalid = wvalid;
    req.bready = bready;
    req.arid = arid; req.araddr = araddr; req.arlen = arlen; req.arsize = 3'd6;
    req.arburst = arburst; req.arvalid = arvalid; req.rready = rready;
  end

  dma_axi_mem_slave dut (
    .clk        (clk),
    .rstn       (rstn),
    .axi_req_i  (req),
    .axi_resp_o (resp),
    .err_cnt_o  (err_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]   id;
    logic [511:0] data;
    logic [1:0]   resp;
    logic         last;
  } r_exp_t;
  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  r_exp_t rq[$];
  b_exp_t bq[$];
  logic [511:0] model [int];

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected expected response", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] wpat(input logic [31:0] seed, input int i);
    if (seed == 32'd0) return 512'(i);
    return {16{seed + 32'(i)}};
  endfunction

  task automatic wait_ready(input int ch, input string nm);
    logic got;
    int n;
    got = 1'b0;
    n = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      case (ch)
        0: got = resp.awready;
        1: got = resp.wready;
        default: got = resp.arready;
      endcase
      tick();
      n++;
    end
    if (!got) fail_now(nm);
  endtask

  task automatic wait_drain(input int which, input string nm);
    int n;
    n = 0;
    while (((which == 0) ? bq.size() : rq.size()) != 0 && n < 200) begin
      tick();
      n++;
    end
    if (((which == 0) ? bq.size() : rq.size()) != 0) fail_now(nm);
  endtask

  task automatic do_write(input logic [3:0] id, input int word, input logic [7:0] len,
                          input logic [1:0] burst, input logic [31:0] seed, input logic [63:0] strb,
                          input int early, input logic [1:0] exp_resp, input bit upd);
    int w;
    b_exp_t e;
    e.id = id;
    e.resp = exp_resp;
    bq.push_back(e);
    awid = id; awaddr = BASE + (32'(word) << 6); awlen = len; awburst = burst; awvalid = 1'b1;
    wait_ready(0, "aw_ready");
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wpat(seed, i);
      wstrb = strb;
      wlast = (early >= 0) ? (i == early) : (i == int'(len));
      wvalid = 1'b1;
      wait_ready(1, "w_ready");
      w = (burst == AXI_BURST_INCR) ? word + i : word;
      if (upd) begin
        if (!model.exists(w)) model[w] = '0;
        for (int b = 0; b < 64; b++) if (strb[b]) model[w][b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    wait_drain(0, "b_timeout");
  endtask

  task automatic push_read(input logic [3:0] id, input int word, input logic [7:0] len,
                           input int nbeats);
    r_exp_t e;
    for (int i = 0; i < nbeats; i++) begin
      e.id = id;
      e.last = (i == int'(len));
      if (word + i < 1024) begin
        e.resp = AXI_RESP_OKAY;
        e.data = model.exists(word + i) ? model[word + i] : 'x;
      end else begin
        e.resp = AXI_RESP_SLVERR;
        e.data = '0;
      end
      rq.push_back(e);
    end
  endtask

  task automatic do_read(input logic [3:0] id, input int word, input logic [7:0] len);
    push_read(id, word, len, int'(len) + 1);
    arid = id; araddr = BASE + (32'(word) << 6); arlen = len; arburst = AXI_BURST_INCR;
    arvalid = 1'b1;
    wait_ready(2, "ar_ready");
    arvalid = 1'b0;
    check("r_first_latency", 512'(resp.rvalid), 512'(1'b1));
    wait_drain(1, "r_timeout");
    tick();
  endtask

  // Response monitor: compares handshakes against the queues and checks R stall stability.
  logic hold_v = 1'b0;
  logic last_seen = 1'b0;
  r_exp_t held;
  always @(negedge clk) begin
    r_exp_t re;
    b_exp_t be;
    if (!rstn) begin
      hold_v = 1'b0;
      last_seen = 1'b0;
    end else begin
      if (last_seen) check("arready_after_last", 512'(resp.arready), 512'(1'b1));
      last_seen = 1'b0;
      if (hold_v && resp.rvalid) begin
        check("r_hold_data", resp.rdata, held.data);
        check("r_hold_last", 512'(resp.rlast), 512'(held.last));
      end
      hold_v = 1'b0;
      if (resp.rvalid && rready) begin
        if (rq.size() == 0) begin
          fail_now("r_unexpected");
        end else begin
          re = rq.pop_front();
          check("r_id", 512'(resp.rid), 512'(re.id));
          check("r_data", resp.rdata, re.data);
          check("r_resp", 512'(resp.rresp), 512'(re.resp));
          check("r_last", 512'(resp.rlast), 512'(re.last));
          if (resp.rlast) last_seen = 1'b1;
        end
      end else if (resp.rvalid) begin
        hold_v = 1'b1;
        held.data = resp.rdata;
        held.last = resp.rlast;
      end
      if (resp.bvalid && bready) begin
        if (bq.size() == 0) begin
          fail_now("b_unexpected");
        end else begin
          be = bq.pop_front();
          check("b_id", 512'(resp.bid), 512'(be.id));
          check("b_resp", 512'(resp.bresp), 512'(be.resp));
        end
      end
    end
  end

  // rready either held high or toggled every cycle for back-pressure.
  initial begin
    forever begin
      tick();
      rready = (rr_mode == 0) ? 1'b1 : ~rready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] exp5;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 512'(resp.awready), 512'(1'b1));
    check("rst_arready", 512'(resp.arready), 512'(1'b1));
    check("rst_wready", 512'(resp.wready), 512'(1'b0));
    check("rst_valids", 512'({resp.bvalid, resp.rvalid}), 512'(2'b00));
    check("rst_err_cnt", 512'(err_cnt), 512'(16'd0));
    rstn = 1'b1;
    tick();

    // write 0..3 then read back
    do_write(4'd1, 0, 8'd3, AXI_BURST_INCR, 32'd0, {64{1'b1}}, -1, AXI_RESP_OKAY, 1'b1);
    do_read(4'd2, 0, 8'd3);

    // partial strobe on word 5
    do_write(4'd3, 5, 8'd0, AXI_BURST_INCR, 32'hFFFF_FFFF, {64{1'b1}}, -1, AXI_RESP_OKAY, 1'b1);
    do_write(4'd3, 5, 8'd0, AXI_BURST_INCR, 32'd0, 64'h0000_0000_0000_000F, -1, AXI_RESP_OKAY, 1'b1);
    exp5 = {512{1'b1}};
    exp5[31:0] = 32'd0;
    model[5] = exp5;
    do_read(4'd4, 5, 8'd0);

    // back-pressure on an 8-beat read
    do_write(4'd5, 16, 8'd7, AXI_BURST_INCR, 32'h1000_0000, {64{1'b1}}, -1, AXI_RESP_OKAY, 1'b1);
    rr_mode = 1;
    do_read(4'd6, 16, 8'd7);
    rr_mode = 0;
    tick();

    // read running off the end, WRAP write rejected
    do_write(4'd7, 1023, 8'd0, AXI_BURST_INCR, 32'h2000_0000, {64{1'b1}}, -1, AXI_RESP_OKAY, 1'b1);
    do_read(4'd8, 1023, 8'd3);
    do_write(4'd9, 10, 8'd0, AXI_BURST_INCR, 32'h3000_0000, {64{1'b1}}, -1, AXI_RESP_OKAY, 1'b1);
    do_write(4'd9, 10, 8'd1, AXI_BURST_WRAP, 32'h4000_0000, {64{1'b1}}, -1, AXI_RESP_SLVERR, 1'b0);
    do_read(4'd10, 10, 8'd0);
    tick();
    check("err_cnt_range", 512'(err_cnt), 512'(16'd4));

    // concurrent write and read with distinct IDs
    fork
      do_write(4'd11, 100, 8'd7, AXI_BURST_INCR, 32'h5000_0000, {64{1'b1}}, -1, AXI_RESP_OKAY, 1'b1);
      do_read(4'd12, 16, 8'd7);
    join
    do_read(4'd13, 100, 8'd7);

    // wlast on beat 2 of a 4-beat write
    do_write(4'd14, 200, 8'd3, AXI_BURST_INCR, 32'h6000_0000, {64{1'b1}}, 2, AXI_RESP_SLVERR, 1'b0);
    tick();
    check("err_cnt_wlast", 512'(err_cnt), 512'(16'd5));

    // reset while beat 2 of a 4-beat read is presented
    push_read(4'd15, 16, 8'd3, 2);
    arid = 4'd15; araddr = BASE + (32'd16 << 6); arlen = 8'd3; arburst = AXI_BURST_INCR;
    arvalid = 1'b1;
    wait_ready(2, "ar_ready_rst");
    arvalid = 1'b0;
    n = 0;
    while (rq.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("rst_beat2_presented", 512'(resp.rvalid), 512'(1'b1));
    rstn = 1'b0;
    #1;
    check("rst_rvalid_drop", 512'(resp.rvalid), 512'(1'b0));
    check("rst_mid_ready", 512'({resp.awready, resp.arready}), 512'(2'b11));
    check("rst_mid_err_cnt", 512'(err_cnt), 512'(16'd0));
    tick();
    tick();
    rstn = 1'b1;
    tick();
    do_read(4'd1, 16, 8'd3);

    repeat (4) tick();
    check("rq_empty", 512'(rq.size()), 512'(0));
    check("bq_empty", 512'(bq.size()), 512'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
